// File: rtl/brisc_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package brisc_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

    // Index reached by stepping 'offset' places past 'base' around a ring of n slots.
    function automatic int wrap_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Requester-side and memory-side bus of the arbiter; slave is the arbiter's view.
interface mem_arbiter_rr_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
);

    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        store_i;
    logic [N_REQ-1:0]        word_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ-1:0]        grant_o;
    logic [N_REQ-1:0]        resp_valid_o;
    logic [LINE_W-1:0]       fill_data_o;
    logic                    mem_req_o;
    logic                    mem_store_o;
    logic                    mem_word_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic [DATA_W-1:0]       mem_data_o;
    logic                    mem_valid_i;
    logic [LINE_W-1:0]       mem_fill_i;
    logic                    timeout_err_o;
    logic                    spurious_err_o;

    modport slave (
        input  req_i, store_i, word_i, addr_i, data_i, mem_valid_i, mem_fill_i,
        output grant_o, resp_valid_o, fill_data_o, mem_req_o, mem_store_o,
        output mem_word_o, mem_addr_o, mem_data_o, timeout_err_o, spurious_err_o
    );

    modport master (
        output req_i, store_i, word_i, addr_i, data_i, mem_valid_i, mem_fill_i,
        input  grant_o, resp_valid_o, fill_data_o, mem_req_o, mem_store_o,
        input  mem_word_o, mem_addr_o, mem_data_o, timeout_err_o, spurious_err_o
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational winner selection: rotate the request vector to start at ptr (or at 0
// when round-robin is off) and take the first set bit.
module rr_picker
    import brisc_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand     = rr_en ? wrap_index(int'(ptr), k, N) : k;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-requester arbiter for the unified memory port: one transaction in flight, grant held
// until the memory responds or the watchdog gives up.
module mem_arbiter_rr
    import brisc_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LINE_W  = 128,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    mem_arbiter_rr_if.slave bus
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam int               WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, ptr_q, pick_idx;
    logic [N_REQ-1:0]  owner_oh_q, pick_oh, resp_valid;
    logic [WD_W-1:0]   wd_q;
    logic              store_q, word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              timeout_err_q, spurious_err_q;
    logic              done, timed_out;

    rr_picker #(.N(N_REQ)) u_picker (
        .req   (bus.req_i),
        .ptr   (ptr_q),
        .rr_en (RR_EN != 0),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // A response on the last watchdog cycle still counts as a normal completion.
    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        timed_out  = 1'b0;
        resp_valid = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|bus.req_i) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus.mem_valid_i) begin
                    resp_valid = owner_oh_q;
                    done       = 1'b1;
                    state_d    = ARB_IDLE;
                end else if (wd_q == WD_LAST) begin
                    timed_out = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q        <= '0;
            owner_oh_q     <= '0;
            ptr_q          <= '0;
            wd_q           <= '0;
            store_q        <= 1'b0;
            word_q         <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            timeout_err_q  <= 1'b0;
            spurious_err_q <= 1'b0;
        end else begin
            wd_q <= (state_q == ARB_WAIT) ? wd_q + 1'b1 : '0;
            if (state_q == ARB_IDLE && |bus.req_i) begin
                owner_q    <= pick_idx;
                owner_oh_q <= pick_oh;
                store_q    <= bus.store_i[pick_idx];
                word_q     <= bus.word_i[pick_idx];
                addr_q     <= bus.addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                data_q     <= bus.data_i[int'(pick_idx)*DATA_W +: DATA_W];
            end
            // An abandoned transaction still moves the pointer so the stuck port cannot hog memory.
            if ((done || timed_out) && RR_EN != 0)
                ptr_q <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            if (timed_out) timeout_err_q <= 1'b1;
            if (state_q == ARB_IDLE && bus.mem_valid_i) spurious_err_q <= 1'b1;
        end
    end

    assign bus.grant_o        = (state_q == ARB_WAIT) ? owner_oh_q : '0;
    assign bus.resp_valid_o   = resp_valid;
    assign bus.fill_data_o    = bus.mem_fill_i[LINE_W-1:0];
    assign bus.mem_req_o      = (state_q == ARB_WAIT);
    assign bus.mem_store_o    = store_q;
    assign bus.mem_word_o     = word_q;
    assign bus.mem_addr_o     = addr_q;
    assign bus.mem_data_o     = data_q;
    assign bus.timeout_err_o  = timeout_err_q;
    assign bus.spurious_err_o = spurious_err_q;

endmodule
